pdp8_mem_arbiter: RTL and testbench

Clocked, parametrised successor to the PDP-8 memory controller. It serves NUM_CH independent requesters (CPU, front panel, DMA) through one shared single-port word array. Requests are arbitrated round-robin, with one memory access per cycle. It supports data read, instruction fetch, write, and an atomic increment-and-test (ISZ-style read-modify-write), and keeps saturating per-type access counters for trace and statistics.

---
 rtl/pdp8_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_pdp8_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_mem_arbiter.sv
// Round-robin arbiter in front of a single-port PDP-8 word memory.
// Supports read, fetch, write and a two-cycle increment-and-test, with saturating access counters.
module pdp8_mem_arbiter #(
  parameter int unsigned WORD_W  = 12,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  input  logic [2*NUM_CH-1:0]        req_op_i,
  input  logic [ADDR_W*NUM_CH-1:0]   req_addr_i,
  input  logic [WORD_W*NUM_CH-1:0]   req_wdata_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  output logic [NUM_CH-1:0]          rsp_valid_o,
  output logic [WORD_W-1:0]          rsp_data_o,
  output logic                       rsp_zero_o,
  output logic [COUNT_W-1:0]         fetch_count_o,
  output logic [COUNT_W-1:0]         read_count_o,
  output logic [COUNT_W-1:0]         write_count_o,
  output logic [COUNT_W-1:0]         inc_count_o
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, INC_WB} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]    rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [NUM_CH-1:0]    inc_ch_q, inc_ch_d;
  logic [ADDR_W-1:0]    inc_addr_q, inc_addr_d;
  logic [WORD_W-1:0]    inc_val_q, inc_val_d;
  logic [COUNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [COUNT_W-1:0]   read_cnt_q, read_cnt_d;
  logic [COUNT_W-1:0]   write_cnt_q, write_cnt_d;
  logic [COUNT_W-1:0]   inc_cnt_q, inc_cnt_d;

  logic [WORD_W-1:0]    mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [WORD_W-1:0]    mem_wdata;

  logic                 found;
  logic [PTR_W-1:0]     gnt_idx;
  logic [NUM_CH-1:0]    grant;
  logic [1:0]           sel_op;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WORD_W-1:0]    sel_wdata;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Upper pass covers channels at or above the pointer, lower pass supplies the wrap-around.
  always_comb begin
    found     = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (state_q == IDLE) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!found && req_valid_i[c] && (PTR_W'(c) >= rr_ptr_q)) begin
          found   = 1'b1;
          gnt_idx = PTR_W'(c);
        end
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!found && req_valid_i[c]) begin
          found   = 1'b1;
          gnt_idx = PTR_W'(c);
        end
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (found && (PTR_W'(c) == gnt_idx)) begin
          grant[c]  = 1'b1;
          sel_op    = req_op_i[2*c +: 2];
          sel_addr  = req_addr_i[ADDR_W*c +: ADDR_W];
          sel_wdata = req_wdata_i[WORD_W*c +: WORD_W];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = 1'b0;
    inc_ch_d    = inc_ch_q;
    inc_addr_d  = inc_addr_q;
    inc_val_d   = inc_val_q;
    fetch_cnt_d = fetch_cnt_q;
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;
    inc_cnt_d   = inc_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = sel_addr;
    mem_wdata   = sel_wdata;
    case (state_q)
      IDLE: begin
        if (found) begin
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          case (sel_op)
            2'b00: begin
              rsp_valid_d = grant;
              rsp_data_d  = mem_q[sel_addr];
              read_cnt_d  = sat_inc(read_cnt_q);
            end
            2'b01: begin
              rsp_valid_d = grant;
              rsp_data_d  = mem_q[sel_addr];
              fetch_cnt_d = sat_inc(fetch_cnt_q);
            end
            2'b10: begin
              mem_we      = 1'b1;
              rsp_valid_d = grant;
              rsp_data_d  = sel_wdata;
              write_cnt_d = sat_inc(write_cnt_q);
            end
            default: begin
              inc_ch_d   = grant;
              inc_addr_d = sel_addr;
              inc_val_d  = mem_q[sel_addr] + 1'b1;
              inc_cnt_d  = sat_inc(inc_cnt_q);
              state_d    = INC_WB;
            end
          endcase
        end
      end
      INC_WB: begin
        mem_we      = 1'b1;
        mem_waddr   = inc_addr_q;
        mem_wdata   = inc_val_q;
        rsp_valid_d = inc_ch_q;
        rsp_data_d  = inc_val_q;
        rsp_zero_d  = (inc_val_q == '0);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      inc_ch_q    <= '0;
      inc_addr_q  <= '0;
      inc_val_q   <= '0;
      fetch_cnt_q <= '0;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      inc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      inc_ch_q    <= inc_ch_d;
      inc_addr_q  <= inc_addr_d;
      inc_val_q   <= inc_val_d;
      fetch_cnt_q <= fetch_cnt_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
      inc_cnt_q   <= inc_cnt_d;
    end
  end

  // Reset blocks both ordinary writes and a pending increment write-back.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) mem_q[mem_waddr] <= mem_wdata;
  end

  assign req_ready_o   = grant;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign fetch_count_o = fetch_cnt_q;
  assign read_count_o  = read_cnt_q;
  assign write_count_o = write_cnt_q;
  assign inc_count_o   = inc_cnt_q;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Directed bench for pdp8_mem_arbiter: a transaction-level memory model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_pdp8_mem_arbiter;
  localparam int WW = 12, AW = 12, NC = 2, CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NC-1:0]     vld;
  logic [2*NC-1:0]   op;
  logic [AW*NC-1:0]  addr;
  logic [WW*NC-1:0]  wd;
  logic [NC-1:0]     rdy, rv;
  logic [WW-1:0]     rdata;
  logic              rzero;
  logic [CW-1:0]     fc, rc, wc, ic;

  logic [NC-1:0]     v2, rdy2, rv2;
  logic [2*NC-1:0]   op2;
  logic [AW*NC-1:0]  addr2;
  logic [WW*NC-1:0]  wd2;
  logic [WW-1:0]     rd2;
  logic              rz2;
  logic [3:0]        fc2, rc2, wc2, ic2;

  pdp8_mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .NUM_CH(NC), .COUNT_W(CW)) dut (
    .clk_i(clk), .reset_i(rst), .req_valid_i(vld), .req_op_i(op), .req_addr_i(addr),
    .req_wdata_i(wd), .req_ready_o(rdy), .rsp_valid_o(rv), .rsp_data_o(rdata),
    .rsp_zero_o(rzero), .fetch_count_o(fc), .read_count_o(rc), .write_count_o(wc),
    .inc_count_o(ic));

  pdp8_mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .NUM_CH(NC), .COUNT_W(4)) dut_sat (
    .clk_i(clk), .reset_i(rst), .req_valid_i(v2), .req_op_i(op2), .req_addr_i(addr2),
    .req_wdata_i(wd2), .req_ready_o(rdy2), .rsp_valid_o(rv2), .rsp_data_o(rd2),
    .rsp_zero_o(rz2), .fetch_count_o(fc2), .read_count_o(rc2), .write_count_o(wc2),
    .inc_count_o(ic2));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: memory array, pending increment, one expected response.
  int  m_mem [4096];
  bit  m_init = 0;
  int  m_ptr, m_busy, wb_addr, wb_val, wb_ch;
  int  e_vch, e_data, e_zero, e_fc, e_rc, e_wc, e_ic;

  int  last_data [NC];
  int  last_zero [NC];
  int  rsp_cyc [NC];
  int  rsp_cnt = 0;
  bit  sweep = 0;
  int  fetch_q [$];

  function automatic int pick(input logic [NC-1:0] v, input int p);
    for (int k = 0; k < NC; k++) begin
      if (v[(p + k) % NC]) return (p + k) % NC;
    end
    return -1;
  endfunction

  function automatic int cinc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(negedge clk) begin : model
    int g, a, w, o;
    logic [NC-1:0] er, ev;
    if (m_init) begin
      g = m_busy ? -1 : pick(vld, m_ptr);
      er = '0; ev = '0;
      if (g >= 0) er[g] = 1'b1;
      if (e_vch >= 0) ev[e_vch] = 1'b1;
      chk("req_ready", int'(rdy), int'(er));
      chk("rsp_valid", int'(rv), int'(ev));
      chk("rsp_data", int'(rdata), e_data);
      chk("rsp_zero", int'(rzero), e_zero);
      chk("fetch_count", int'(fc), e_fc);
      chk("read_count", int'(rc), e_rc);
      chk("write_count", int'(wc), e_wc);
      chk("inc_count", int'(ic), e_ic);
    end else begin
      g = -1;
    end
    for (int c = 0; c < NC; c++) begin
      if (rv[c]) begin
        last_data[c] = int'(rdata);
        last_zero[c] = int'(rzero);
        rsp_cyc[c]   = cyc;
        rsp_cnt++;
        if (sweep && c == 1) begin
          if (fetch_q.size() == 0) chk("sweep_fetch_q", 0, 1);
          else chk("sweep_fetch", int'(rdata), fetch_q.pop_front());
        end
      end
    end
    if (rst) begin
      m_init = 1; m_ptr = 0; m_busy = 0;
      e_vch = -1; e_data = 0; e_zero = 0;
      e_fc = 0; e_rc = 0; e_wc = 0; e_ic = 0;
    end else if (m_init) begin
      e_vch = -1; e_zero = 0;
      if (m_busy != 0) begin
        m_mem[wb_addr] = wb_val;
        e_vch = wb_ch; e_data = wb_val; e_zero = (wb_val == 0) ? 1 : 0;
        m_busy = 0;
      end else if (g >= 0) begin
        m_ptr = (g + 1) % NC;
        a = int'(addr[AW*g +: AW]);
        w = int'(wd[WW*g +: WW]);
        o = int'(op[2*g +: 2]);
        case (o)
          0: begin e_vch = g; e_data = m_mem[a]; e_rc = cinc(e_rc); end
          1: begin e_vch = g; e_data = m_mem[a]; e_fc = cinc(e_fc); end
          2: begin e_vch = g; e_data = w; m_mem[a] = w; e_wc = cinc(e_wc); end
          default: begin
            m_busy = 1; wb_addr = a; wb_ch = g;
            wb_val = (m_mem[a] + 1) % (1 << WW);
            e_ic = cinc(e_ic);
          end
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  // Present one request on channel ch, wait for the grant, then withdraw it.
  task automatic req(input int ch, input int o, input int a, input int w, output int xc);
    int n;
    vld[ch] = 1'b1;
    op[2*ch +: 2]    = 2'(o);
    addr[AW*ch +: AW] = AW'(a);
    wd[WW*ch +: WW]  = WW'(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[ch] && n < 50);
    if (!rdy[ch]) chk("grant_timeout", 0, 1);
    xc = cyc;
    if (sweep && ch == 1) fetch_q.push_back(a);
    @(posedge clk);
    #1;
    vld[ch] = 1'b0;
  endtask

  initial begin : stim
    int xc, xr, snap, n;
    logic [NC-1:0] gseq [6];
    rst = 1'b1; vld = '0; op = '0; addr = '0; wd = '0;
    v2 = '0; op2 = '0; addr2 = '0; wd2 = '0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(rdy), 0);
    chk("reset_rsp_valid", int'(rv), 0);
    chk("reset_rsp_data", int'(rdata), 0);
    chk("reset_counts", int'(fc) + int'(rc) + int'(wc) + int'(ic), 0);
    idle(1);

    req(0, 2, 'o200, 'o333, xc);
    idle(2);
    chk("write_ack_data", last_data[0], 'o333);
    chk("write_ack_latency", rsp_cyc[0] - xc, 1);
    req(0, 0, 'o200, 0, xc);
    idle(2);
    chk("read_data", last_data[0], 'o333);
    chk("read_latency", rsp_cyc[0] - xc, 1);
    chk("write_count_1", int'(wc), 1);
    chk("read_count_1", int'(rc), 1);

    do_reset();
    addr = {AW'('o200), AW'('o200)};
    op = '0;
    vld = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gseq[i] = rdy;
      chk("rr_grant", int'(rdy), (i % 2 == 0) ? 1 : 2);
      if (i > 0) chk("rr_rsp_follows", int'(rv), int'(gseq[i-1]));
    end
    @(posedge clk);
    #1;
    vld = '0;
    @(negedge clk);
    chk("rr_rsp_follows_last", int'(rv), int'(gseq[5]));
    idle(1);

    req(0, 2, 'o10, 'o7777, xc);
    req(0, 3, 'o10, 0, xc);
    req(1, 0, 'o10, 0, xr);
    chk("inc_blocks_next", xr - xc, 2);
    idle(2);
    chk("inc_wrap_data", last_data[0], 0);
    chk("inc_wrap_zero", last_zero[0], 1);
    chk("inc_latency", rsp_cyc[0] - xc, 2);
    chk("read_after_inc", last_data[1], 0);
    req(0, 2, 'o11, 5, xc);
    req(0, 3, 'o11, 0, xc);
    idle(3);
    chk("inc_data", last_data[0], 6);
    chk("inc_zero", last_zero[0], 0);

    req(0, 2, 'o20, 'o41, xc);
    req(0, 3, 'o20, 0, xc);
    snap = rsp_cnt;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    chk("reset_kills_inc_rsp", rsp_cnt - snap, 0);
    chk("reset_kills_counts", int'(fc) + int'(rc) + int'(wc) + int'(ic), 0);
    req(0, 0, 'o20, 0, xc);
    idle(2);
    chk("reset_kills_wb", last_data[0], 'o41);

    do_reset();
    sweep = 1;
    for (int a = 0; a < 4096; a++) begin
      req(0, 2, a, a, xc);
      req(1, 1, a, 0, xc);
    end
    idle(2);
    sweep = 0;
    chk("sweep_fetch_count", int'(fc), 4096);
    chk("sweep_write_count", int'(wc), 4096);
    chk("sweep_all_answered", fetch_q.size(), 0);

    do_reset();
    v2 = 2'b01;
    n = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      chk("sat_read_count", int'(rc2), (n > 15) ? 15 : n);
      if (rdy2[0]) n++;
    end
    @(posedge clk);
    #1;
    v2 = '0;
    chk("sat_final", int'(rc2), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
